// File: rtl/microop_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// microop_sequencer_pkg
//   Shared constants for the microcode sequencer and the plane decoders that
//   sit downstream of the microcode store: in-plane codes, register-select
//   codes, control-word field positions and opword field positions.
// ---------------------------------------------------------------------------
package microop_sequencer_pkg;

   // in_plane codes (CTRL[14:12])
   localparam logic [2:0] IN_REG    = 3'd1;
   localparam logic [2:0] IN_TMP0   = 3'd2;
   localparam logic [2:0] IN_TMP1   = 3'd3;
   localparam logic [2:0] IN_OPWORD = 3'd5;
   localparam logic [2:0] IN_OPCODE = 3'd6;

   // reg_sel codes (CTRL[7:6]); code 3 selects register 0
   localparam logic [1:0] REG_SEL_OPCODE_REG0 = 2'd0;
   localparam logic [1:0] REG_SEL_OPCODE_REG1 = 2'd1;
   localparam logic [1:0] REG_SEL_CONTROL     = 2'd2;

   localparam logic OPCODE_SEL_OPCODE_FROM_BUS = 1'b1;
   localparam logic MISC_RESET_MICROOP_COUNTER = 1'b1;

   // control word field positions
   localparam int CTRL_DATA_LO   = 0;
   localparam int CTRL_DATA_HI   = 5;
   localparam int REG_SEL_LO     = 6;
   localparam int REG_SEL_HI     = 7;
   localparam int IN_PLANE_LO    = 12;
   localparam int IN_PLANE_HI    = 14;
   localparam int MISC_BIT       = 15;
   localparam int OPCODE_SEL_BIT = 22;

   // opword field positions
   localparam int OW_OPCODE_HI = 31;
   localparam int OW_OPCODE_LO = 26;
   localparam int OW_RD_HI     = 25;
   localparam int OW_RD_LO     = 21;
   localparam int OW_RS_HI     = 20;
   localparam int OW_RS_LO     = 16;
   localparam int OW_OFFSET_HI = 15;
   localparam int OW_OFFSET_LO = 0;

   // well-known opcodes
   localparam logic [5:0] OP_RESET = 6'd0;
   localparam logic [5:0] OP_FETCH = 6'd1;

endpackage

// File: rtl/microop_sequencer_ctrl_fields.sv
// ---------------------------------------------------------------------------
// ctrl_fields
//   Purely combinational unpacker of the 32-bit microcode control word into
//   named fields. Shared with the downstream plane decoders.
//   Ports:
//     ctrl        in  32  control word from the microcode store
//     ctrl_data   out 6   immediate / register number field
//     reg_sel     out 2   register-file address source select
//     in_plane    out 3   destination plane for the bus this cycle
//     misc        out 1   micro-op counter reset
//     opcode_sel  out 1   opcode source: 1 = bus, 0 = opword register
// ---------------------------------------------------------------------------
module ctrl_fields
   import microop_sequencer_pkg::*;
(
   input  logic [31:0] ctrl,
   output logic [5:0]  ctrl_data,
   output logic [1:0]  reg_sel,
   output logic [2:0]  in_plane,
   output logic        misc,
   output logic        opcode_sel
);

   assign ctrl_data  = ctrl[CTRL_DATA_HI:CTRL_DATA_LO];
   assign reg_sel    = ctrl[REG_SEL_HI:REG_SEL_LO];
   assign in_plane   = ctrl[IN_PLANE_HI:IN_PLANE_LO];
   assign misc       = ctrl[MISC_BIT];
   assign opcode_sel = ctrl[OPCODE_SEL_BIT];

   // Bits owned by other planes; not interpreted here.
   logic unused_ctrl_bits;
   assign unused_ctrl_bits = ^{ctrl[31:23], ctrl[21:16], ctrl[11:8]};

endmodule

// File: rtl/microop_sequencer.sv
// ---------------------------------------------------------------------------
// microop_sequencer
//   Holds the current opcode, micro-op counter and opword register and
//   drives {opcode, count} into the microcode store. The control word for
//   the current address comes back in the same cycle and selects the next
//   opcode/count/opword. Also resolves the register-select field into a
//   5-bit register-file address.
//
//   Optional feature: define OVERFLOW_TRAP_EN to trap micro-op counter
//   overflow (return to RESET_OPCODE and set the sticky FAULT flag).
//   Without it the counter wraps and FAULT is tied low.
//
//   Ports:
//     CLK       in  1   clock, rising edge
//     N_RST     in  1   asynchronous active-low reset
//     N_BOOTED  in  1   high while the microcode store is being loaded
//     STALL     in  1   freeze all state
//     CTRL      in  32  control word from the microcode store
//     BUS       in  32  shared data bus
//     ADDR      out 11  {opcode, count} to the microcode store (registered)
//     OPWORD    out 32  opword register
//     REG_ADDR  out 5   register-file address (combinational)
//     FAULT     out 1   sticky micro-op counter overflow flag
// ---------------------------------------------------------------------------
module microop_sequencer
   import microop_sequencer_pkg::*;
#(
   parameter int OPCODE_W     = 6,
   parameter int COUNT_W      = 5,
   parameter int RESET_OPCODE = 0
)
(
   input  logic                        CLK,
   input  logic                        N_RST,
   input  logic                        N_BOOTED,
   input  logic                        STALL,
   input  logic [31:0]                 CTRL,
   input  logic [31:0]                 BUS,
   output logic [OPCODE_W+COUNT_W-1:0] ADDR,
   output logic [31:0]                 OPWORD,
   output logic [4:0]                  REG_ADDR,
   output logic                        FAULT
);

   localparam logic [OPCODE_W-1:0] RESET_OP  = OPCODE_W'(RESET_OPCODE);
   localparam logic [COUNT_W-1:0]  COUNT_MAX = {COUNT_W{1'b1}};

   logic [5:0] ctrl_data;
   logic [1:0] reg_sel;
   logic [2:0] in_plane;
   logic       misc;
   logic       opcode_sel;

   ctrl_fields u_ctrl_fields (
      .ctrl       (CTRL),
      .ctrl_data  (ctrl_data),
      .reg_sel    (reg_sel),
      .in_plane   (in_plane),
      .misc       (misc),
      .opcode_sel (opcode_sel)
   );

   logic [OPCODE_W-1:0] opcode_reg, opcode_next;
   logic [COUNT_W-1:0]  count_reg,  count_next;
   logic [31:0]         opword_reg, opword_next;
   logic                fault_next;

   // Only ctrl_data[4:0] forms a register number.
   logic unused_ctrl_data_msb;
   assign unused_ctrl_data_msb = ctrl_data[5];

   always_comb begin
      opcode_next = opcode_reg;
      count_next  = count_reg;
      opword_next = opword_reg;
      fault_next  = FAULT;
      if (N_BOOTED) begin
         // Store contents are not valid yet: park on the reset micro-op.
         opcode_next = RESET_OP;
         count_next  = '0;
      end else if (!STALL) begin
         if (in_plane == IN_OPWORD)
            opword_next = BUS;
         // Dispatch from the opword uses the value held before this edge,
         // so a same-cycle opword load does not feed the opcode.
         if (in_plane == IN_OPCODE)
            opcode_next = (opcode_sel == OPCODE_SEL_OPCODE_FROM_BUS)
                        ? BUS[OPCODE_W-1:0]
                        : OPCODE_W'(opword_reg[OW_OPCODE_HI:OW_OPCODE_LO]);
         if (misc == MISC_RESET_MICROOP_COUNTER)
            count_next = '0;
         else
            count_next = count_reg + COUNT_W'(1);
`ifdef OVERFLOW_TRAP_EN
         // Trap overrides any opcode load in the same cycle.
         if (misc != MISC_RESET_MICROOP_COUNTER && count_reg == COUNT_MAX) begin
            opcode_next = RESET_OP;
            count_next  = '0;
            fault_next  = 1'b1;
         end
`endif
      end
   end

`ifdef OVERFLOW_TRAP_EN
   logic fault_reg;
   assign FAULT = fault_reg;
`else
   assign FAULT = 1'b0;
   logic unused_overflow;
   assign unused_overflow = fault_next ^ (count_reg == COUNT_MAX);
`endif

   always_ff @(posedge CLK or negedge N_RST) begin
      if (!N_RST) begin
         opcode_reg <= RESET_OP;
         count_reg  <= '0;
         opword_reg <= '0;
`ifdef OVERFLOW_TRAP_EN
         fault_reg  <= 1'b0;
`endif
      end else begin
         opcode_reg <= opcode_next;
         count_reg  <= count_next;
         opword_reg <= opword_next;
`ifdef OVERFLOW_TRAP_EN
         fault_reg  <= fault_next;
`endif
      end
   end

   assign ADDR   = {opcode_reg, count_reg};
   assign OPWORD = opword_reg;

   always_comb begin
      REG_ADDR = 5'd0;
      case (reg_sel)
         REG_SEL_OPCODE_REG0: REG_ADDR = opword_reg[OW_RD_HI:OW_RD_LO];
         REG_SEL_OPCODE_REG1: REG_ADDR = opword_reg[OW_RS_HI:OW_RS_LO];
         REG_SEL_CONTROL:     REG_ADDR = ctrl_data[4:0];
         default:             REG_ADDR = 5'd0;
      endcase
   end

endmodule

// File: tb/tb_microop_sequencer.sv
// ---------------------------------------------------------------------------
// tb_microop_sequencer
//   Scoreboard bench: each step pushes its expected outputs, applies inputs,
//   and the outputs are popped and compared one cycle later (or right away
//   for the combinational REG_ADDR). Expectations follow OVERFLOW_TRAP_EN.
// ---------------------------------------------------------------------------
module tb_microop_sequencer;

   localparam int SIG_ADDR   = 0;
   localparam int SIG_OPWORD = 1;
   localparam int SIG_REGA   = 2;
   localparam int SIG_FAULT  = 3;

   logic        CLK = 1'b0;
   logic        N_RST, N_BOOTED, STALL;
   logic [31:0] CTRL, BUS;
   logic [10:0] ADDR;
   logic [31:0] OPWORD;
   logic [4:0]  REG_ADDR;
   logic        FAULT;

   int n_compared   = 0;
   int n_mismatched = 0;

   typedef struct {
      string       tag;
      int          sig;
      logic [31:0] val;
   } exp_t;
   exp_t sb[$];

   microop_sequencer dut (
      .CLK      (CLK),
      .N_RST    (N_RST),
      .N_BOOTED (N_BOOTED),
      .STALL    (STALL),
      .CTRL     (CTRL),
      .BUS      (BUS),
      .ADDR     (ADDR),
      .OPWORD   (OPWORD),
      .REG_ADDR (REG_ADDR),
      .FAULT    (FAULT)
   );

   always #5 CLK = ~CLK;

   function automatic logic [31:0] mk_ctrl(input logic [2:0] plane, input logic sel,
                                           input logic misc, input logic [1:0] rs,
                                           input logic [5:0] cd);
      logic [31:0] c;
      c        = 32'd0;
      c[14:12] = plane;
      c[22]    = sel;
      c[15]    = misc;
      c[7:6]   = rs;
      c[5:0]   = cd;
      return c;
   endfunction

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_compared++;
      if (obs !== exp_v) begin
         n_mismatched++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp_v);
      end else begin
         $display("ok   %s = 0x%08h", tag, obs);
      end
   endtask

   task automatic push_exp(input string tag, input int sig, input logic [31:0] val);
      exp_t e;
      e.tag = tag;
      e.sig = sig;
      e.val = val;
      sb.push_back(e);
   endtask

   task automatic drain();
      exp_t        e;
      logic [31:0] act;
      while (sb.size() != 0) begin
         e = sb.pop_front();
         case (e.sig)
            SIG_ADDR:   act = {21'd0, ADDR};
            SIG_OPWORD: act = OPWORD;
            SIG_REGA:   act = {27'd0, REG_ADDR};
            default:    act = {31'd0, FAULT};
         endcase
         check_val(e.tag, act, e.val);
      end
   endtask

   // Apply inputs, clock once, compare everything queued for this step.
   task automatic cycle(input logic [31:0] ctrl, input logic [31:0] bus);
      CTRL = ctrl;
      BUS  = bus;
      @(posedge CLK);
      #1;
      drain();
   endtask

   // Apply inputs and compare the combinational response without clocking.
   task automatic comb(input logic [31:0] ctrl);
      CTRL = ctrl;
      #1;
      drain();
   endtask

   logic        fault_exp;
   logic [10:0] ovf_addr_exp;

   initial begin
`ifdef OVERFLOW_TRAP_EN
      fault_exp    = 1'b1;
      ovf_addr_exp = 11'h000;
`else
      fault_exp    = 1'b0;
      ovf_addr_exp = 11'h020;
`endif
      N_RST = 1'b0; N_BOOTED = 1'b1; STALL = 1'b0; CTRL = 32'd0; BUS = 32'd0;
      #2;
      push_exp("rst_addr", SIG_ADDR, 32'h0);
      push_exp("rst_opword", SIG_OPWORD, 32'h0);
      push_exp("rst_fault", SIG_FAULT, 32'h0);
      drain();
      #10 N_RST = 1'b1;

      // Boot hold with garbage control words.
      for (int i = 0; i < 5; i++) begin
         push_exp("boot_addr", SIG_ADDR, 32'h0);
         push_exp("boot_opword", SIG_OPWORD, 32'h0);
         cycle($urandom, $urandom);
      end
      N_BOOTED = 1'b0;
      push_exp("boot_rel_addr0", SIG_ADDR, 32'h0);
      comb(32'd0);
      push_exp("boot_rel_addr1", SIG_ADDR, 32'h1);
      cycle(mk_ctrl(3'd0, 1'b0, 1'b0, 2'd0, 6'd0), 32'd0);

      // Dispatch from bus.
      push_exp("disp_bus", SIG_ADDR, 32'h020);
      cycle(mk_ctrl(3'd6, 1'b1, 1'b1, 2'd0, 6'd0), 32'h0000_0001);

      // Opword load then dispatch from opword.
      push_exp("ow_load_addr", SIG_ADDR, 32'h021);
      push_exp("ow_load", SIG_OPWORD, 32'h0865_1234);
      cycle(mk_ctrl(3'd5, 1'b0, 1'b0, 2'd0, 6'd0), 32'h0865_1234);
      push_exp("disp_ow", SIG_ADDR, 32'h040);
      cycle(mk_ctrl(3'd6, 1'b0, 1'b1, 2'd0, 6'd0), 32'hFFFF_FFFF);

      // Register selects.
      push_exp("regsel_rd", SIG_REGA, 32'd3);
      comb(mk_ctrl(3'd0, 1'b0, 1'b0, 2'd0, 6'd0));
      push_exp("step_041", SIG_ADDR, 32'h041);
      cycle(CTRL, 32'd0);
      push_exp("regsel_rs", SIG_REGA, 32'd5);
      comb(mk_ctrl(3'd0, 1'b0, 1'b0, 2'd1, 6'd0));
      push_exp("step_042", SIG_ADDR, 32'h042);
      cycle(CTRL, 32'd0);
      push_exp("regsel_ctrl", SIG_REGA, 32'd31);
      comb(mk_ctrl(3'd0, 1'b0, 1'b0, 2'd2, 6'd31));
      push_exp("regsel_zero", SIG_REGA, 32'd0);
      comb(mk_ctrl(3'd0, 1'b0, 1'b0, 2'd3, 6'd31));

      // Walk to 0x022, then stall.
      push_exp("stall_pre0", SIG_ADDR, 32'h020);
      cycle(mk_ctrl(3'd6, 1'b1, 1'b1, 2'd0, 6'd0), 32'h0000_0001);
      push_exp("stall_pre1", SIG_ADDR, 32'h021);
      cycle(32'd0, 32'd0);
      push_exp("stall_pre2", SIG_ADDR, 32'h022);
      cycle(32'd0, 32'd0);
      STALL = 1'b1;
      for (int i = 0; i < 3; i++) begin
         push_exp("stall_addr", SIG_ADDR, 32'h022);
         push_exp("stall_opword", SIG_OPWORD, 32'h0865_1234);
         if (i == 2)
            cycle(mk_ctrl(3'd5, 1'b0, 1'b1, 2'd0, 6'd0), 32'hDEAD_BEEF);
         else
            cycle(mk_ctrl(3'd6, 1'b1, 1'b1, 2'd0, 6'd0), 32'h0000_0007);
      end
      STALL = 1'b0;
      push_exp("stall_rel0", SIG_ADDR, 32'h023);
      cycle(32'd0, 32'd0);
      push_exp("stall_rel1", SIG_ADDR, 32'h024);
      cycle(32'd0, 32'd0);

      // Overflow from {opcode 1, count 0}.
      push_exp("ovf_start", SIG_ADDR, 32'h020);
      cycle(mk_ctrl(3'd6, 1'b1, 1'b1, 2'd0, 6'd0), 32'h0000_0001);
      for (int i = 1; i <= 31; i++) begin
         push_exp("ovf_count", SIG_ADDR, 32'h020 + i);
         push_exp("ovf_fault0", SIG_FAULT, 32'h0);
         cycle(32'd0, 32'd0);
      end
      push_exp("ovf_addr", SIG_ADDR, {21'd0, ovf_addr_exp});
      push_exp("ovf_fault", SIG_FAULT, {31'd0, fault_exp});
      cycle(32'd0, 32'd0);

      // Boot hold beats stall; fault is sticky.
      STALL = 1'b1; N_BOOTED = 1'b1;
      push_exp("boot_over_stall", SIG_ADDR, 32'h0);
      push_exp("fault_sticky", SIG_FAULT, {31'd0, fault_exp});
      cycle(mk_ctrl(3'd6, 1'b1, 1'b0, 2'd0, 6'd0), 32'h0000_0003);
      STALL = 1'b0; N_BOOTED = 1'b0;
      push_exp("post_boot_step", SIG_ADDR, 32'h1);
      cycle(32'd0, 32'd0);

      // Asynchronous reset mid-cycle clears everything.
      #3 N_RST = 1'b0;
      #1;
      push_exp("async_rst_addr", SIG_ADDR, 32'h0);
      push_exp("async_rst_opword", SIG_OPWORD, 32'h0);
      push_exp("async_rst_fault", SIG_FAULT, 32'h0);
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule

// File: doc/microop_sequencer.md
# microop_sequencer

Holds the current opcode, micro-op counter and opword register, and drives the 11-bit address into the microcode store. It sits directly upstream of the microcode lookup. It consumes the control word that lookup returns in the same cycle and uses it to decide the next opcode, counter and opword. It also resolves the control word's register-select field into a 5-bit register-file address.

## Interface
Parameters:
- OPCODE_W, 6, opcode width; ADDR[10:5].
- COUNT_W, 5, micro-op counter width; ADDR[4:0].
- RESET_OPCODE, 0, opcode entered on reset, boot hold and trap.

Ports:
- CLK  in  1  system clock; all state updates on its rising edge.
- N_RST  in  1  reset; asynchronous, active-low.
- N_BOOTED  in  1  high while bootstrap is loading the microcode store; sequencer held.
- STALL  in  1  high freezes all state (e.g. memory not ready).
- CTRL  in  32  control word from microcode: [5:0] ctrl_data, [7:6] reg_sel, [14:12] in_plane, [15] misc (counter reset), [22] opcode_sel.
- BUS  in  32  shared data bus.
- ADDR  out  11  {opcode, count} to microcode store; registered.
- OPWORD  out  32  opword register; [31:26] opcode, [25:21] rD, [20:16] rS, [15:0] offset.
- REG_ADDR  out  5  reg_sel 0 → rD, 1 → rS, 2 → ctrl_data[4:0], 3 → 0; combinational.
- FAULT  out  1  sticky micro-op overflow flag; constant 0 when the trap is compiled out.

## Operation
- State: opcode (OPCODE_W), count (COUNT_W), opword (32), fault (1).
- Each edge, when N_BOOTED=0 and STALL=0, the following updates apply:
  - If in_plane==IN_OPWORD (5): opword ← BUS.
  - If in_plane==IN_OPCODE (6): opcode ← opcode_sel ? BUS[5:0] : OPWORD[31:26]. The opword source is the register value before this edge.
  - If misc=1: count ← 0; otherwise count ← count+1.
  - A simultaneous opcode load and counter reset is legal and is the normal dispatch. The next cycle addresses {new opcode, 0}.
- N_BOOTED=1: opcode ← RESET_OPCODE, count ← 0, opword held, fault held. CTRL is ignored because the store output is not valid.
- STALL=1 with N_BOOTED=0: all state held, CTRL ignored. N_BOOTED takes priority over STALL.
- Counter overflow (count==2^COUNT_W−1, misc=0, not stalled): see Configuration.
- Unused in_plane codes have no effect on this block.

## Timing
- Reset (N_RST low, asynchronous): opcode=RESET_OPCODE, count=0, OPWORD=0, FAULT=0. ADDR therefore reads 0.
- ADDR is registered. CTRL is assumed valid combinationally within the same cycle.
- Zero-cycle feedback: the control word for address A determines the address for the next cycle.
- REG_ADDR has combinational latency from CTRL and OPWORD.
- Release of N_RST or N_BOOTED: the first active edge executes micro-op {RESET_OPCODE, 0}.

## Configuration
- OVERFLOW_TRAP_EN defined:
  - On counter overflow, opcode ← RESET_OPCODE, count ← 0, FAULT ← 1.
  - FAULT is cleared only by N_RST.
  - An opcode load in the same cycle is overridden by the trap.
- Not defined:
  - The counter wraps to 0 and the opcode is kept, or loaded as normal.
  - FAULT is tied 0.

## Structure
- Shared package holds:
  - In-plane codes (IN_REG=1, IN_TMP0=2, IN_TMP1=3, IN_OPWORD=5, IN_OPCODE=6).
  - REG_SEL codes (0 opcode reg0, 1 opcode reg1, 2 control).
  - OPCODE_SEL_OPCODE_FROM_BUS=1 and MISC_RESET_MICROOP_COUNTER=1.
  - CTRL field bit ranges.
  - Opword field ranges.
  - OP_RESET=0 and OP_FETCH=1.
- One sub-module, ctrl_fields: a combinational unpacker of the 32-bit CTRL into named fields. It is shared with the downstream plane decoders.

## Test plan
- Reset/boot sequence:
  - Stimulus: N_RST pulse, then N_BOOTED high for 5 cycles with random CTRL.
  - Required response: ADDR=0 throughout. After release, ADDR=0 on the first cycle and 1 on the next with CTRL misc=0.
- Dispatch from bus:
  - Stimulus: at ADDR=0x001 drive CTRL {in_plane=6, opcode_sel=1, misc=1} and BUS=0x00000001.
  - Required response: next ADDR=0x020 (opcode 1, count 0).
- Opword dispatch:
  - Stimulus: load BUS=0x0865_1234 via in_plane=5, then in_plane=6 with opcode_sel=0 and misc=1.
  - Required response: OPWORD=0x08651234 and next ADDR=0x040 (opcode 2). REG_ADDR with reg_sel=0 is 3 and with reg_sel=1 is 5.
- Control register select:
  - Stimulus: reg_sel=2, ctrl_data=31.
  - Required response: REG_ADDR=31.
- Stall:
  - Stimulus: STALL high for 3 cycles at ADDR=0x022 while CTRL requests an opcode load.
  - Required response: ADDR stays 0x022 and OPWORD is unchanged. After release, ADDR advances once per cycle.
- Overflow:
  - Stimulus: run 31 cycles with misc=0 from count 0, opcode 1.
  - Required response with OVERFLOW_TRAP_EN: ADDR goes 0x03F → 0x000 and FAULT=1.
  - Required response without it: ADDR goes 0x03F → 0x020 and FAULT=0.
